// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the decode-side handoff.
// master = fetch unit, slave = memory/decode/branch side.
interface fetch_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 8
);
  logic                   pc_sel;
  logic [PC_WIDTH-1:0]    branch_target;
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [PC_WIDTH-1:0]    instr_pc;
  logic                   instr_valid;
  logic                   decode_ready;

  modport master (
    input  pc_sel, branch_target, imem_rdata, imem_rvalid, decode_ready,
    output imem_req, imem_addr, instr_out, instr_pc, instr_valid
  );

  modport slave (
    output pc_sel, branch_target, imem_rdata, imem_rvalid, decode_ready,
    input  imem_req, imem_addr, instr_out, instr_pc, instr_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// PC + single-outstanding instruction fetch with a one-entry decode buffer and branch redirect.
// Latency: req one cycle after START/HOLD, instruction valid the cycle after the response.
// Backpressure: decode_ready=0 holds the buffered instruction and stalls further requests.
module fetch_unit #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  fif
);

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic                capture;
  logic                vld_clr;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    vld_clr   = 1'b0;
    case (state)
      S_START: state_nxt = S_FETCH;
      S_FETCH: begin
        if (fif.pc_sel) begin
          pc_nxt    = fif.branch_target;
          state_nxt = S_DRAIN;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect coinciding with the response throws the response away.
        if (fif.pc_sel) begin
          pc_nxt    = fif.branch_target;
          state_nxt = fif.imem_rvalid ? S_FETCH : S_DRAIN;
        end else if (fif.imem_rvalid) begin
          capture   = 1'b1;
          pc_nxt    = pc + PC_WIDTH'(1);
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (fif.pc_sel) begin
          pc_nxt    = fif.branch_target;
          vld_clr   = 1'b1;
          state_nxt = S_FETCH;
        end else if (fif.decode_ready) begin
          vld_clr   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (fif.pc_sel) pc_nxt = fif.branch_target;
        if (fif.imem_rvalid) state_nxt = S_FETCH;
      end
      default: state_nxt = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_START;
      pc              <= RESET_PC;
      fif.imem_req    <= 1'b0;
      fif.imem_addr   <= '0;
      fif.instr_out   <= {INSTR_WIDTH{1'b0}};
      fif.instr_pc    <= '0;
      fif.instr_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      // Request registered from the next state so it is high exactly during FETCH.
      fif.imem_req <= (state_nxt == S_FETCH);
      if (state_nxt == S_FETCH) fif.imem_addr <= pc_nxt;
      if (capture) begin
        fif.instr_out <= fif.imem_rdata;
        fif.instr_pc  <= pc;
      end
      if (capture)      fif.instr_valid <= 1'b1;
      else if (vld_clr) fif.instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table for streaming/backpressure, hand sequences for redirects and reset.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   lat   = 1;

  fetch_if #(.PC_WIDTH(8), .INSTR_WIDTH(8)) fif ();

  fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: response lat cycles after the request; data = addr ^ 0x5A.
  initial begin
    int         cnt;
    logic [7:0] raddr;
    cnt = 0;
    raddr = 8'h00;
    fif.imem_rvalid = 1'b0;
    fif.imem_rdata  = 8'h00;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        cnt = 0;
        fif.imem_rvalid = 1'b0;
      end else begin
        fif.imem_rvalid = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            fif.imem_rvalid = 1'b1;
            fif.imem_rdata  = raddr ^ 8'h5A;
          end
        end
        if (fif.imem_req === 1'b1) begin
          cnt   = lat;
          raddr = fif.imem_addr;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rdy;
    logic       req;
    logic [7:0] addr;
    logic       vld;
    logic [7:0] ipc;
    logic [7:0] iout;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_vld(input string nm);
    int k;
    k = 0;
    while (fif.instr_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (fif.instr_valid !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s: instr_valid got %b after 20 cycles, expected 1", nm, fif.instr_valid);
    end
  endtask

  initial begin
    int  seen_k;
    logic seen;

    // rdy, req, addr, vld, ipc, iout  (cycle 0 = START after release)
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h5A};
    tbl[4]  = '{1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 8'h5A};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h5A};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 8'h5B};
    tbl[7]  = '{1'b1, 1'b1, 8'h02, 1'b0, 8'h01, 8'h5B};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 8'h5B};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'h58};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'h58};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'h58};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'h58};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'h58};
    tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 8'h58};
    tbl[15] = '{1'b1, 1'b1, 8'h03, 1'b0, 8'h02, 8'h58};

    rst_n = 1'b0;
    fif.pc_sel = 1'b0;
    fif.branch_target = 8'h00;
    fif.decode_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_req",   fif.imem_req,    0);
    chk("rst_addr",  fif.imem_addr,   0);
    chk("rst_vld",   fif.instr_valid, 0);
    chk("rst_ipc",   fif.instr_pc,    0);
    chk("rst_iout",  fif.instr_out,   0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("row%0d_req", i),  fif.imem_req,    tbl[i].req);
      chk($sformatf("row%0d_vld", i),  fif.instr_valid, tbl[i].vld);
      chk($sformatf("row%0d_ipc", i),  fif.instr_pc,    tbl[i].ipc);
      chk($sformatf("row%0d_iout", i), fif.instr_out,   tbl[i].iout);
      if (tbl[i].req) chk($sformatf("row%0d_addr", i), fif.imem_addr, tbl[i].addr);
      fif.decode_ready = tbl[i].rdy;
    end

    // Redirect from HOLD (no accept) to 0xFF, then wrap to 0x00.
    @(negedge clk);
    @(negedge clk);
    chk("h03_vld", fif.instr_valid, 1);
    chk("h03_ipc", fif.instr_pc, 8'h03);
    fif.pc_sel = 1'b1; fif.branch_target = 8'hFF; fif.decode_ready = 1'b0;
    @(negedge clk);
    chk("ff_req",  fif.imem_req, 1);
    chk("ff_addr", fif.imem_addr, 8'hFF);
    chk("ff_vld",  fif.instr_valid, 0);
    fif.pc_sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hff_ipc",  fif.instr_pc, 8'hFF);
    chk("hff_iout", fif.instr_out, 8'hA5);
    fif.decode_ready = 1'b1;
    @(negedge clk);
    chk("wrap_req",  fif.imem_req, 1);
    chk("wrap_addr", fif.imem_addr, 8'h00);

    // Redirect during FETCH of 0x05 with latency 3: drained, refetch at 0x40.
    wait_vld("hold00");
    lat = 3;
    fif.pc_sel = 1'b1; fif.branch_target = 8'h05;
    @(negedge clk);
    chk("f05_req",  fif.imem_req, 1);
    chk("f05_addr", fif.imem_addr, 8'h05);
    fif.branch_target = 8'h40;
    @(negedge clk);
    fif.pc_sel = 1'b0;
    seen = 1'b0;
    seen_k = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      chk($sformatf("drain%0d_vld", k), fif.instr_valid, 0);
      if (fif.imem_req === 1'b1) begin
        seen = 1'b1;
        seen_k = k;
      end else begin
        @(negedge clk);
      end
    end
    chk("drain_cycles", seen_k[15:0], 4);
    chk("f40_addr", fif.imem_addr, 8'h40);
    wait_vld("hold40");
    chk("h40_ipc",  fif.instr_pc, 8'h40);
    chk("h40_iout", fif.instr_out, 8'h1A);

    // Redirect coincident with the response in WAIT.
    lat = 1;
    @(negedge clk);
    chk("f41_req",  fif.imem_req, 1);
    chk("f41_addr", fif.imem_addr, 8'h41);
    @(negedge clk);
    fif.pc_sel = 1'b1; fif.branch_target = 8'h10;
    @(negedge clk);
    fif.pc_sel = 1'b0;
    chk("f10_req",  fif.imem_req, 1);
    chk("f10_addr", fif.imem_addr, 8'h10);
    chk("f10_vld",  fif.instr_valid, 0);
    chk("f10_ipc",  fif.instr_pc, 8'h40);
    wait_vld("hold10");
    chk("h10_ipc",  fif.instr_pc, 8'h10);
    chk("h10_iout", fif.instr_out, 8'h4A);

    // Get to HOLD at 0x20, then redirect with decode_ready=1.
    fif.pc_sel = 1'b1; fif.branch_target = 8'h20;
    @(negedge clk);
    fif.pc_sel = 1'b0;
    chk("f20_addr", fif.imem_addr, 8'h20);
    wait_vld("hold20");
    chk("h20_ipc",  fif.instr_pc, 8'h20);
    chk("h20_iout", fif.instr_out, 8'h7A);
    fif.pc_sel = 1'b1; fif.branch_target = 8'h08; fif.decode_ready = 1'b1;
    @(negedge clk);
    fif.pc_sel = 1'b0;
    chk("f08_vld",  fif.instr_valid, 0);
    chk("f08_req",  fif.imem_req, 1);
    chk("f08_addr", fif.imem_addr, 8'h08);
    chk("f08_ipc",  fif.instr_pc, 8'h20);

    // Reset pulse in WAIT.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_req",  fif.imem_req, 0);
    chk("mrst_addr", fif.imem_addr, 0);
    chk("mrst_vld",  fif.instr_valid, 0);
    chk("mrst_ipc",  fif.instr_pc, 0);
    chk("mrst_iout", fif.instr_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart_start_req", fif.imem_req, 0);
    @(negedge clk);
    chk("restart_req",  fif.imem_req, 1);
    chk("restart_addr", fif.imem_addr, 8'h00);
    wait_vld("restart_hold");
    chk("restart_ipc",  fif.instr_pc, 8'h00);
    chk("restart_iout", fif.instr_out, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Program-counter and instruction-fetch stage of the 8-bit CPU. It is the direct consumer of the branch decision's pc_sel.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Buffers one fetched instruction for decode.
- Redirects to branch_target and flushes wrong-path work when pc_sel is asserted.

Parameters:
PC_WIDTH, 8, program counter and instruction address width
INSTR_WIDTH, 8, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
pc_sel  input  1  redirect request from branch decision; 1 = take branch_target
branch_target  input  PC_WIDTH  redirect address, valid when pc_sel=1
imem_req  output  1  one-cycle instruction memory read request
imem_addr  output  PC_WIDTH  read address, valid when imem_req=1
imem_rdata  input  INSTR_WIDTH  read data, valid when imem_rvalid=1
imem_rvalid  input  1  read response strobe; arrives ≥1 cycle after imem_req
instr_out  output  INSTR_WIDTH  buffered instruction to decode
instr_pc  output  PC_WIDTH  address of instr_out
instr_valid  output  1  instr_out/instr_pc hold a live instruction
decode_ready  input  1  decode accepts instr_out this cycle when instr_valid=1

Behaviour:
Reset (asynchronous assert, synchronous release):
- pc=RESET_PC, state=START, imem_req=0, imem_addr=0, instr_out=0, instr_pc=0, instr_valid=0.
- Reset during any state discards any outstanding request; a late imem_rvalid after release is ignored only if it arrives in START (no other guarantee; memory is reset together).

State machine, 5 states:
- START: idle one cycle after reset release -> FETCH.
- FETCH: imem_req=1, imem_addr=pc -> WAIT.
- WAIT: imem_req=0. On imem_rvalid: instr_out<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1 (modulo 2^PC_WIDTH, 0xFF wraps to 0x00) -> HOLD.
- HOLD: instr_valid=1, outputs stable. On decode_ready: instr_valid<=0 -> FETCH. Fetch-to-fetch throughput is 1 instruction per 3 cycles with 1-cycle memory latency.
- DRAIN: waits for the wrong-path response. On imem_rvalid: data discarded -> FETCH.

imem_req is a registered output and is high only in FETCH.

Redirect (pc_sel=1, highest priority, evaluated in every state except START):
- pc<=branch_target; instr_valid<=0 next cycle.
- From FETCH: request already issued -> DRAIN.
- From WAIT, imem_rvalid=0 -> DRAIN.
- From WAIT, imem_rvalid=1: response discarded, pc/instr buffers not updated from it -> FETCH.
- From HOLD: instruction flushed. If decode_ready is also 1, the handshake still counts as accepted; the redirect belongs to that instruction. -> FETCH.
- From DRAIN: pc updated, stay DRAIN unless imem_rvalid=1 (then -> FETCH).
- pc_sel in START is ignored.
- pc_sel held high for several cycles re-applies each cycle; the last target wins.

Invariants:
- At most one outstanding memory request.
- imem_rvalid outside WAIT/DRAIN is ignored.
- instr_out/instr_pc change only on a WAIT capture.

Test Plan:
- Reset release, RESET_PC=0, memory latency 1, decode_ready=1 -> imem_req at cycle 2 with addr 0x00; instr_valid with instr_pc=0x00, 0x01, 0x02 every 3 cycles.
- decode_ready=0 for 5 cycles while instr_valid=1 -> instr_out/instr_pc stable, no imem_req; release -> next req to pc+1.
- pc=0xFF fetched -> next imem_addr=0x00.
- pc_sel=1 with target 0x40 in the FETCH cycle of addr 0x05, memory latency 3 -> data for 0x05 discarded, instr_valid stays 0, next imem_req addr=0x40.
- pc_sel=1 (target 0x10) coincident with imem_rvalid in WAIT -> no instr_valid for old data, next req addr=0x10 one cycle later.
- pc_sel=1 and decode_ready=1 in HOLD (instr_pc=0x20, target 0x08) -> instr_valid drops, next req addr=0x08; rst_n pulsed low mid-WAIT -> all outputs at reset values immediately, restart at RESET_PC.
